// File: rtl/snake_body_streamer_if.sv
// Controller/renderer side bundle of the snake body streamer.
// master drives moves and head position, slave is the streamer.
interface snake_body_streamer_if #(
  parameter int SNAKE_LENGTH_BIT = 4
);
  logic                        move_tick;
  logic                        grow;
  logic [6:0]                  snake_head_x;
  logic [6:0]                  snake_head_y;
  logic [SNAKE_LENGTH_BIT-1:0] body_count;
  logic [6:0]                  snake_body_x;
  logic [6:0]                  snake_body_y;
  logic [SNAKE_LENGTH_BIT-1:0] snake_length;
  logic                        update_busy;
  logic                        self_hit;

  modport master (
    output move_tick, grow,
    output snake_head_x, snake_head_y,
    input  body_count, snake_body_x, snake_body_y,
    input  snake_length, update_busy, self_hit
  );

  modport slave (
    input  move_tick, grow,
    input  snake_head_x, snake_head_y,
    output body_count, snake_body_x, snake_body_y,
    output snake_length, update_busy, self_hit
  );
endinterface

// File: rtl/snake_body_streamer.sv
// Snake body list: shift on move, grow on fruit, scan for self-hit,
// and stream every entry to the renderer one per clock.
module snake_body_streamer #(
  parameter int SNAKE_LENGTH_BIT = 4,
  parameter int SNAKE_LENGTH_MAX = 16,
  parameter int INIT_LENGTH      = 3,
  parameter int INIT_X           = 20,
  parameter int INIT_Y           = 20
) (
  input  logic                  clock_25,
  input  logic                  reset,
  snake_body_streamer_if.slave  bus
);
  localparam int LB = SNAKE_LENGTH_BIT;
  localparam int NE = SNAKE_LENGTH_MAX - 1;
  localparam logic [LB-1:0] LAST   = LB'(NE - 1);
  localparam logic [LB-1:0] LEN_MX = LB'(NE);

  typedef enum logic [1:0] {IDLE, SHIFT, SCAN} state_t;

  state_t                  state_q, state_d;
  logic [NE-1:0][6:0]      ent_x_q, ent_x_d;
  logic [NE-1:0][6:0]      ent_y_q, ent_y_d;
  logic [LB-1:0]           stream_idx_q, stream_idx_d;
  logic [LB-1:0]           body_count_q, body_count_d;
  logic [6:0]              body_x_q, body_x_d;
  logic [6:0]              body_y_q, body_y_d;
  logic [LB-1:0]           len_q, len_d;
  logic [LB-1:0]           scan_idx_q, scan_idx_d;
  logic [6:0]              old_x_q, old_x_d;
  logic [6:0]              old_y_q, old_y_d;
  logic                    grow_q, grow_d;
  logic                    hit_q, hit_d;

  always_comb begin
    state_d      = state_q;
    ent_x_d      = ent_x_q;
    ent_y_d      = ent_y_q;
    len_d        = len_q;
    scan_idx_d   = scan_idx_q;
    old_x_d      = old_x_q;
    old_y_d      = old_y_q;
    grow_d       = grow_q;
    hit_d        = hit_q;
    // stream index is the entry presented on the next clock
    stream_idx_d = (stream_idx_q == LAST) ? '0
                 : stream_idx_q + 1'b1;
    body_count_d = stream_idx_q;
    body_x_d     = ent_x_q[stream_idx_q];
    body_y_d     = ent_y_q[stream_idx_q];

    unique case (state_q)
      IDLE: begin
        if (bus.move_tick) begin
          old_x_d = bus.snake_head_x;
          old_y_d = bus.snake_head_y;
          grow_d  = bus.grow;
          hit_d   = 1'b0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        for (int i = NE - 1; i >= 1; i--) begin
          ent_x_d[i] = ent_x_q[i-1];
          ent_y_d[i] = ent_y_q[i-1];
        end
        ent_x_d[0] = old_x_q;
        ent_y_d[0] = old_y_q;
        if (grow_q && len_q < LEN_MX) begin
          len_d = len_q + 1'b1;
        end
        scan_idx_d = '0;
        state_d    = SCAN;
      end
      SCAN: begin
        if (ent_x_q[scan_idx_q] == bus.snake_head_x &&
            ent_y_q[scan_idx_q] == bus.snake_head_y) begin
          hit_d = 1'b1;
        end
        if (scan_idx_q == len_q - 1'b1) begin
          state_d = IDLE;
        end else begin
          scan_idx_d = scan_idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_25) begin
    if (reset) begin
      state_q      <= IDLE;
      for (int i = 0; i < NE; i++) begin
        ent_x_q[i] <= (i < INIT_LENGTH) ? 7'(INIT_X - 1 - i) : 7'd0;
        ent_y_q[i] <= (i < INIT_LENGTH) ? 7'(INIT_Y) : 7'd0;
      end
      stream_idx_q <= LB'(1 % NE);
      body_count_q <= '0;
      body_x_q     <= 7'(INIT_X - 1);
      body_y_q     <= 7'(INIT_Y);
      len_q        <= LB'(INIT_LENGTH);
      scan_idx_q   <= '0;
      old_x_q      <= '0;
      old_y_q      <= '0;
      grow_q       <= 1'b0;
      hit_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      ent_x_q      <= ent_x_d;
      ent_y_q      <= ent_y_d;
      stream_idx_q <= stream_idx_d;
      body_count_q <= body_count_d;
      body_x_q     <= body_x_d;
      body_y_q     <= body_y_d;
      len_q        <= len_d;
      scan_idx_q   <= scan_idx_d;
      old_x_q      <= old_x_d;
      old_y_q      <= old_y_d;
      grow_q       <= grow_d;
      hit_q        <= hit_d;
    end
  end

  assign bus.body_count   = body_count_q;
  assign bus.snake_body_x = body_x_q;
  assign bus.snake_body_y = body_y_q;
  assign bus.snake_length = len_q;
  assign bus.update_busy  = (state_q != IDLE);
  assign bus.self_hit     = hit_q;
endmodule
